ram_prog_loader: RTL

Initiator side of the 16-byte DFF program RAM: drives mar, write data, lr_n and ce_n. Two jobs:
- Load: fill the RAM from a byte stream on a valid/ready input.
- Dump: read the RAM back out on a valid/ready output.
It sits between the external programming interface and the RAM, and keeps a running 8-bit checksum of the transfer.

---
 rtl/ram_prog_pkg.sv | 30 +++
 rtl/ram_prog_csum.sv | 37 +++
 rtl/ram_prog_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ram_prog_pkg.sv
//------------------------------------------------------------------------------
// Module   : ram_prog_pkg
// Purpose  : Shared types and defaults for the program-RAM loader slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_prog_pkg;

    localparam int   c_ADDR_BITS = 4;
    localparam int   c_RAM_BYTES = 16;
    localparam int   c_DATA_BITS = 8;

    // Idle (inactive) levels of the active-low RAM strobes
    localparam logic c_LR_N_RST  = 1'b1;
    localparam logic c_CE_N_RST  = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        LFLUSH   = 3'd2,
        RD_ISSUE = 3'd3,
        RD_CAPT  = 3'd4,
        RD_OUT   = 3'd5,
        DONE     = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_prog_csum.sv
//------------------------------------------------------------------------------
// Module   : ram_prog_csum
// Purpose  : Wrap-around byte accumulator with synchronous clear and add enable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_prog_csum
    import ram_prog_pkg::*;
#(
    parameter int DATA_BITS = c_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_add_en,
    input  logic [DATA_BITS-1:0] i_add_val,
    output logic [DATA_BITS-1:0] o_sum
);

    logic [DATA_BITS-1:0] r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add_en) begin
            r_sum <= r_sum + i_add_val;
        end
    end

    assign o_sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/ram_prog_loader.sv
//------------------------------------------------------------------------------
// Module   : ram_prog_loader
// Purpose  : Loads the program RAM from a byte stream and dumps it back out,
//            keeping a running mod-256 checksum of the transfer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_prog_loader
    import ram_prog_pkg::*;
#(
    parameter int ADDR_BITS = c_ADDR_BITS,
    parameter int RAM_BYTES = c_RAM_BYTES,
    parameter int DATA_BITS = c_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_load,
    input  logic                 start_dump,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] checksum,
    output logic [ADDR_BITS-1:0] mar,
    output logic [DATA_BITS-1:0] ram_wdata,
    output logic                 lr_n,
    output logic                 ce_n,
    input  logic [DATA_BITS-1:0] ram_rdata
);

    localparam logic [ADDR_BITS:0] c_LAST_PTR = (ADDR_BITS+1)'(RAM_BYTES - 1);

    state_t                 r_state,     w_state_nxt;
    logic [ADDR_BITS:0]     r_ptr,       w_ptr_nxt;
    logic [ADDR_BITS:0]     w_ptr_inc;
    logic [ADDR_BITS-1:0]   r_mar,       w_mar_nxt;
    logic [DATA_BITS-1:0]   r_wdata,     w_wdata_nxt;
    logic [DATA_BITS-1:0]   r_out_data,  w_out_data_nxt;
    logic                   r_lr_n,      w_lr_n_nxt;
    logic                   r_ce_n,      w_ce_n_nxt;
    logic                   r_out_valid, w_out_valid_nxt;
    logic                   w_csum_clr;
    logic                   w_csum_add;
    logic [DATA_BITS-1:0]   w_csum_val;

    assign w_ptr_inc = r_ptr + (ADDR_BITS+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_mar       <= '0;
            r_wdata     <= '0;
            r_out_data  <= '0;
            r_lr_n      <= c_LR_N_RST;
            r_ce_n      <= c_CE_N_RST;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_mar       <= w_mar_nxt;
            r_wdata     <= w_wdata_nxt;
            r_out_data  <= w_out_data_nxt;
            r_lr_n      <= w_lr_n_nxt;
            r_ce_n      <= w_ce_n_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Strobes default to inactive, so each is low for exactly one cycle per request
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_mar_nxt       = r_mar;
        w_wdata_nxt     = r_wdata;
        w_out_data_nxt  = r_out_data;
        w_lr_n_nxt      = c_LR_N_RST;
        w_ce_n_nxt      = c_CE_N_RST;
        w_out_valid_nxt = r_out_valid;
        w_csum_clr      = 1'b0;
        w_csum_add      = 1'b0;
        w_csum_val      = in_data;

        case (r_state)
            IDLE: begin
                if (start_load) begin
                    w_state_nxt = LOAD;
                    w_ptr_nxt   = '0;
                    w_csum_clr  = 1'b1;
                end else if (start_dump) begin
                    w_state_nxt = RD_ISSUE;
                    w_ptr_nxt   = '0;
                    w_mar_nxt   = '0;
                    w_ce_n_nxt  = 1'b0;
                    w_csum_clr  = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    w_mar_nxt   = r_ptr[ADDR_BITS-1:0];
                    w_wdata_nxt = in_data;
                    w_lr_n_nxt  = 1'b0;
                    w_csum_add  = 1'b1;
                    w_ptr_nxt   = w_ptr_inc;
                    if (r_ptr == c_LAST_PTR) begin
                        w_state_nxt = LFLUSH;
                    end
                end
            end
            LFLUSH: begin
                w_state_nxt = DONE;
            end
            RD_ISSUE: begin
                w_state_nxt = RD_CAPT;
            end
            RD_CAPT: begin
                w_out_data_nxt  = ram_rdata;
                w_out_valid_nxt = 1'b1;
                w_csum_add      = 1'b1;
                w_csum_val      = ram_rdata;
                w_state_nxt     = RD_OUT;
            end
            RD_OUT: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_ptr_nxt       = w_ptr_inc;
                    if (r_ptr == c_LAST_PTR) begin
                        w_state_nxt = DONE;
                    end else begin
                        // Next read address and enable go out together, one cycle ahead
                        w_state_nxt = RD_ISSUE;
                        w_mar_nxt   = w_ptr_inc[ADDR_BITS-1:0];
                        w_ce_n_nxt  = 1'b0;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    ram_prog_csum #(
        .DATA_BITS (DATA_BITS)
    ) u_csum (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_csum_clr),
        .i_add_en  (w_csum_add),
        .i_add_val (w_csum_val),
        .o_sum     (checksum)
    );

    assign in_ready  = (r_state == LOAD);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign mar       = r_mar;
    assign ram_wdata = r_wdata;
    assign lr_n      = r_lr_n;
    assign ce_n      = r_ce_n;

endmodule

`default_nettype wire
